// File: rtl/pcileech_pkg.sv
// Shared definitions for the pcileech status-LED logic.
package pcileech_pkg;

    typedef enum logic {
        LED_NORMAL,
        LED_ERR
    } led_fsm_t;

    localparam int LED_ERR_TOGGLES = 8;

endpackage

// File: rtl/pcileech_led_stretch.sv
// Retriggerable activity stretcher: a strobe holds 'active' for CYCLES cycles.
module pcileech_led_stretch #(
    parameter int CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic active
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (strobe) begin
            cnt_d = CW'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reports the count held next cycle so the caller's output register lines up with it.
    assign active = (cnt_d != '0);

endmodule

// File: rtl/pcileech_led_ctl.sv
// Status-LED policy for the Screamer M2: heartbeat, activity stretch, error blink.
module pcileech_led_ctl
    import pcileech_pkg::*;
#(
    parameter int PARAM_STRETCH_CYCLES   = 5_000_000,
    parameter int PARAM_HEARTBEAT_CYCLES = 50_000_000,
    parameter bit PARAM_INVERT           = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic link_up,
    input  logic act_pcie,
    input  logic act_com,
    input  logic err,
    output logic led_ld1,
    output logic led_ld2
);

    localparam int HB_W   = $clog2(PARAM_HEARTBEAT_CYCLES + 1);
    localparam int FAST   = PARAM_HEARTBEAT_CYCLES >> 3;
    localparam int FAST_W = $clog2(FAST + 1);

    logic pcie_active;
    logic com_active;

    pcileech_led_stretch #(.CYCLES(PARAM_STRETCH_CYCLES)) u_stretch_pcie (
        .clk    (clk),
        .rst    (rst),
        .strobe (act_pcie),
        .active (pcie_active)
    );

    pcileech_led_stretch #(.CYCLES(PARAM_STRETCH_CYCLES)) u_stretch_com (
        .clk    (clk),
        .rst    (rst),
        .strobe (act_com),
        .active (com_active)
    );

    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic              hb_phase_q, hb_phase_d;
    led_fsm_t          state_q, state_d;
    logic [FAST_W-1:0] fast_cnt_q, fast_cnt_d;
    logic [3:0]        tog_cnt_q, tog_cnt_d;
    logic              blink_q, blink_d;
    logic              ld1_q, ld1_d;
    logic              ld2_q, ld2_d;

    always_comb begin
        hb_cnt_d   = hb_cnt_q + HB_W'(1);
        hb_phase_d = hb_phase_q;
        if (hb_cnt_q == HB_W'(PARAM_HEARTBEAT_CYCLES - 1)) begin
            hb_cnt_d   = '0;
            hb_phase_d = ~hb_phase_q;
        end
    end

    // The final toggle of the error burst is the one that hands control back to NORMAL.
    always_comb begin
        state_d    = state_q;
        fast_cnt_d = fast_cnt_q;
        tog_cnt_d  = tog_cnt_q;
        blink_d    = blink_q;
        ld1_d      = 1'b0;
        ld2_d      = 1'b0;

        if (err) begin
            state_d    = LED_ERR;
            fast_cnt_d = '0;
            tog_cnt_d  = '0;
            blink_d    = 1'b1;
        end else if (state_q == LED_ERR) begin
            if (fast_cnt_q == FAST_W'(FAST - 1)) begin
                fast_cnt_d = '0;
                blink_d    = ~blink_q;
                tog_cnt_d  = tog_cnt_q + 4'd1;
                if (tog_cnt_q == 4'(LED_ERR_TOGGLES - 1)) begin
                    state_d = LED_NORMAL;
                end
            end else begin
                fast_cnt_d = fast_cnt_q + FAST_W'(1);
            end
        end

        if (state_d == LED_ERR) begin
            ld1_d = blink_d;
            ld2_d = blink_d;
        end else begin
            ld1_d = link_up ? ~pcie_active : hb_phase_d;
            ld2_d = com_active;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q   <= '0;
            hb_phase_q <= 1'b0;
            state_q    <= LED_NORMAL;
            fast_cnt_q <= '0;
            tog_cnt_q  <= '0;
            blink_q    <= 1'b0;
            ld1_q      <= 1'b0;
            ld2_q      <= 1'b0;
        end else begin
            hb_cnt_q   <= hb_cnt_d;
            hb_phase_q <= hb_phase_d;
            state_q    <= state_d;
            fast_cnt_q <= fast_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
            blink_q    <= blink_d;
            ld1_q      <= ld1_d;
            ld2_q      <= ld2_d;
        end
    end

    assign led_ld1 = ld1_q ^ PARAM_INVERT;
    assign led_ld2 = ld2_q ^ PARAM_INVERT;

endmodule

// File: tb/tb_pcileech_led_ctl.sv
// Bench for pcileech_led_ctl: directed vector table, heartbeat run length, random traffic vs. an event-time model.
module tb_pcileech_led_ctl;

    localparam int STRETCH = 4;
    localparam int HB      = 16;
    localparam int FAST    = HB >> 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, link_up = 1'b0, act_pcie = 1'b0, act_com = 1'b0, err = 1'b0;
    logic ld1, ld2, ild1, ild2;

    pcileech_led_ctl #(
        .PARAM_STRETCH_CYCLES(STRETCH), .PARAM_HEARTBEAT_CYCLES(HB), .PARAM_INVERT(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .link_up(link_up), .act_pcie(act_pcie),
        .act_com(act_com), .err(err), .led_ld1(ld1), .led_ld2(ld2)
    );

    pcileech_led_ctl #(
        .PARAM_STRETCH_CYCLES(STRETCH), .PARAM_HEARTBEAT_CYCLES(HB), .PARAM_INVERT(1'b1)
    ) u_inv (
        .clk(clk), .rst(rst), .link_up(link_up), .act_pcie(act_pcie),
        .act_com(act_com), .err(err), .led_ld1(ild1), .led_ld2(ild2)
    );

    typedef struct {
        string tag;
        logic  r, l, p, c, e;
        logic  x1, x2;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // Event-time reference model: only the latest qualifying event of each kind matters.
    int   cyc = 0;
    int   r0 = 0;
    int   last_p = -1000, last_c = -1000, last_e = -1000;
    logic rst_prev = 1'b1, link_prev = 1'b0;

    function automatic void add(input string tag, input logic r, l, p, c, e, x1, x2);
        vec_t v;
        v.tag = tag; v.r = r; v.l = l; v.p = p; v.c = c; v.e = e; v.x1 = x1; v.x2 = x2;
        vecs.push_back(v);
    endfunction

    function automatic logic [1:0] model_out(input int t);
        logic [1:0] o;
        logic pa, ca;
        int d;
        if (rst_prev) return 2'b00;
        pa = (t - last_p >= 1) && (t - last_p <= STRETCH);
        ca = (t - last_c >= 1) && (t - last_c <= STRETCH);
        o[1] = link_prev ? ~pa : ((((t - r0) / HB) % 2) == 1);
        o[0] = ca;
        d = t - last_e;
        if (d >= 1 && d <= 8 * FAST) o = ((((d - 1) / FAST) % 2) == 0) ? 2'b11 : 2'b00;
        return o;
    endfunction

    task automatic compare(input string name, input logic [1:0] exp);
        logic [3:0] got, want;
        got  = {ld1, ld2, ild1, ild2};
        want = {exp, ~exp};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d ld1,ld2,inv_ld1,inv_ld2 got=%b required=%b", name, cyc, got, want);
        end
    endtask

    task automatic step(input logic r, l, p, c, e, input bit use_tbl, input logic [1:0] tbl_exp,
                        input string tag);
        rst = r; link_up = l; act_pcie = p; act_com = c; err = e;
        @(posedge clk);
        if (r) begin
            r0 = cyc + 1;
            last_p = -1000; last_c = -1000; last_e = -1000;
        end else begin
            if (p) last_p = cyc;
            if (c) last_c = cyc;
            if (e) last_e = cyc;
        end
        rst_prev = r;
        link_prev = l;
        cyc++;
        #1;
        compare({"model_", tag}, model_out(cyc));
        if (use_tbl) compare(tag, tbl_exp);
    endtask

    initial begin
        logic prev;
        bit   seen;
        int   run;
        logic rl, ll;

        // Reset with link down, then heartbeat: low through (r0 .. r0+15), high for the next 16.
        for (int i = 0; i < 3; i++) add("reset", 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 33; k++) add("heartbeat", 0, 0, 0, 0, 0, (((k + 1) / HB) % 2) == 1, 0);
        // COM single strobe: high N+1..N+4, low N+5.
        add("com_single", 0, 1, 0, 1, 0, 1, 1);
        for (int j = 1; j < 6; j++) add("com_single", 0, 1, 0, 0, 0, 1, j < 4);
        // Retrigger at N+3: high until N+7, low at N+8.
        for (int j = 0; j < 8; j++) add("com_retrig", 0, 1, 0, (j == 0 || j == 3), 0, 1, j < 7);
        // PCIe with link up: ld1 low N+1..N+4.
        for (int j = 0; j < 6; j++) add("pcie_act", 0, 1, (j == 0), 0, 0, j >= 4, 0);
        // Error blink, then NORMAL at N+17.
        for (int j = 0; j < 17; j++)
            add("err_blink", 0, 1, 0, 0, (j == 0), (j < 16) ? ((j / FAST) % 2 == 0) : 1'b1,
                (j < 16) ? ((j / FAST) % 2 == 0) : 1'b0);
        // Second err at N+5 restarts the burst.
        for (int j = 0; j < 23; j++) begin
            int k;
            k = (j < 5) ? j : j - 5;
            add("err_restart", 0, 1, 0, 0, (j == 0 || j == 5), (k < 16) ? ((k / FAST) % 2 == 0) : 1'b1,
                (k < 16) ? ((k / FAST) % 2 == 0) : 1'b0);
        end
        // err together with act_com: blink wins, stretch expired afterwards.
        for (int j = 0; j < 17; j++)
            add("err_com", 0, 1, 0, (j == 0), (j == 0), (j < 16) ? ((j / FAST) % 2 == 0) : 1'b1,
                (j < 16) ? ((j / FAST) % 2 == 0) : 1'b0);
        // Reset at N+6 of a burst aborts it.
        for (int j = 0; j < 6; j++) add("err_rst", 0, 1, 0, 0, (j == 0), (j / FAST) % 2 == 0, (j / FAST) % 2 == 0);
        add("err_rst", 1, 1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 20; j++) add("err_rst_after", 0, 1, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].l, vecs[i].p, vecs[i].c, vecs[i].e, 1'b1, {vecs[i].x1, vecs[i].x2}, vecs[i].tag);
            $display("vec %0d %s in rst=%b link=%b pcie=%b com=%b err=%b out=%b%b", i, vecs[i].tag,
                     vecs[i].r, vecs[i].l, vecs[i].p, vecs[i].c, vecs[i].e, ld1, ld2);
        end

        // Drop link: ld1 follows heartbeat next cycle, then each level lasts exactly HB cycles.
        step(0, 0, 0, 0, 0, 1'b0, 2'b00, "link_drop");
        $display("link_drop out=%b%b", ld1, ld2);
        prev = ld1;
        seen = 0;
        for (int i = 0; i < 2 * HB + 2 && !seen; i++) begin
            step(0, 0, 0, 0, 0, 1'b0, 2'b00, "hb_wait");
            if (ld1 !== prev) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hb_edge no ld1 transition within %0d cycles, required one", 2 * HB + 2);
        end else begin
            run = 1;
            prev = ld1;
            for (int i = 0; i < 2 * HB + 2; i++) begin
                step(0, 0, 0, 0, 0, 1'b0, 2'b00, "hb_run");
                if (ld1 !== prev) break;
                run++;
            end
            checks++;
            if (run != HB) begin
                errors++;
                $display("FAIL hb_run level length got=%0d required=%0d", run, HB);
            end
            $display("hb_run level=%b length=%0d", prev, run);
        end

        // Random traffic against the model.
        ll = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            logic p, c, e;
            rl = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) ll = ~ll;
            p = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 59) == 0);
            step(rl, ll, p, c, e, 1'b0, 2'b00, "random");
            if (rl || e)
                $display("random cyc=%0d rst=%b link=%b pcie=%b com=%b err=%b out=%b%b", cyc, rl, ll, p, c, e, ld1, ld2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcileech_led_ctl.md
# pcileech_led_ctl

Status-LED controller for the Screamer M2 board, sitting between the PCIe/COM cores and the `user_led_ld1`/`user_led_ld2` pads.

- Converts single-cycle activity strobes and the PCIe link-up level into human-visible LED patterns.
- Patterns: heartbeat while the link is down, retriggerable activity stretching, and a fast error-blink override.
- Replaces the raw `led_state` wiring so all LED policy lives in one registered block in the `clk` domain.

## Interface
Parameters:
- `PARAM_STRETCH_CYCLES`, 5_000_000: activity pulse stretch length in `clk` cycles (≥2).
- `PARAM_HEARTBEAT_CYCLES`, 50_000_000: half-period of the link-down heartbeat (≥16).
- `PARAM_INVERT`, 0: 1 = active-low LED pads; XORed onto both outputs.

Ports:
- `clk` in 1: 100 MHz system clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `link_up` in 1: PCIe link-up level (already synchronous to `clk`).
- `act_pcie` in 1: one-cycle strobe per PCIe TLP moved.
- `act_com` in 1: one-cycle strobe per FT601 transfer.
- `err` in 1: one-cycle error strobe (FIFO overflow, bad command).
- `led_ld1` out 1: link/PCIe LED.
- `led_ld2` out 1: COM LED.

## Operation
- Stretcher (one per activity input):
  - Down-counter loaded with `PARAM_STRETCH_CYCLES` on a strobe; decrements to 0; `active` = count≠0.
  - A strobe while already active reloads the counter (retrigger).
- Heartbeat:
  - Free-running counter 0..`PARAM_HEARTBEAT_CYCLES`-1.
  - `hb_phase` toggles each time the counter wraps.
  - Runs regardless of `link_up`.
- NORMAL-state LED values:
  - `ld1` = `link_up` ? ~pcie_active : hb_phase. Steady on when link is up; blinks off during PCIe activity.
  - `ld2` = com_active.
- Error FSM, states NORMAL / ERR:
  - `err` → ERR. Clears the fast counter, toggle count = 0, and sets both LEDs on.
  - Fast period FAST = `PARAM_HEARTBEAT_CYCLES`>>3. Every FAST cycles both LEDs toggle together.
  - After the 8th toggle → NORMAL.
  - `err` while in ERR restarts the sequence (toggle count 0, LEDs on).
- Simultaneous events:
  - `err` has priority over activity for the outputs.
  - Stretchers and the heartbeat keep counting during ERR, so NORMAL resumes with their current values.
- Widths: each counter is `$clog2(param+1)` bits. Toggle count is 4 bits. No wrap other than the heartbeat.
- Reset:
  - All counters 0, `hb_phase`=0, FSM=NORMAL, internal LED regs 0.
  - Outputs = `PARAM_INVERT`.
  - Reset mid-ERR or mid-stretch aborts immediately.

## Timing
- Outputs are registered; no combinational input-to-output path.
- Strobe at cycle N → LED change visible at N+1.
- Stretch window: a strobe at N keeps the LED asserted N+1 … N+`PARAM_STRETCH_CYCLES`, deasserted at N+`PARAM_STRETCH_CYCLES`+1. A retrigger at M extends this to M+`PARAM_STRETCH_CYCLES`.
- Heartbeat: `ld1` spends exactly `PARAM_HEARTBEAT_CYCLES` cycles in each level; full period is 2×.
- `link_up` change at N → `ld1` follows at N+1 (if NORMAL).
- Error: `err` at N → both LEDs on N+1 … N+FAST, toggling every FAST cycles. NORMAL values return at N+8·FAST+1.
- During `rst`=1 and on the first cycle after it, outputs = `PARAM_INVERT`.

## Structure
- Shared package `pcileech_pkg`: `led_fsm_t` enum {LED_NORMAL, LED_ERR}; constant `LED_ERR_TOGGLES`=8.
- Sub-module `pcileech_led_stretch` (parameter CYCLES; ports `clk`, `rst`, `strobe`, `active`), instantiated twice.
- Top-level edit: `pcileech_screamer_m2_top` drives its pads from this block.

## Test plan
All scenarios use STRETCH=4, HB=16 (FAST=2), INVERT=0.
- **Reset, link down:** hold `rst` 3 cycles, `link_up`=0 → both LEDs 0 during reset and 1 cycle after; `ld1` then alternates 16 cycles low / 16 cycles high; `ld2` stays 0.
- **COM single strobe and retrigger:** `act_com` at N → `ld2` high N+1..N+4, low N+5. Strobes at N and N+3 → high N+1..N+7, low N+8.
- **PCIe activity with link up:** `link_up`=1, `act_pcie` at N → `ld1` low N+1..N+4, high from N+5. Drop `link_up` → heartbeat value next cycle.
- **Error blink:** `err` at N → both LEDs 1,1,0,0,1,1,… over N+1..N+16, then NORMAL values at N+17. A second `err` at N+5 → sequence restarts, ends at N+21.
- **Error with simultaneous activity:** `err` and `act_com` at N → error pattern shown; after the sequence, `ld2` is 0 because the stretch has expired.
- **Reset mid-ERR:** assert `rst` at N+6 of an error sequence → outputs 0 at N+7; no further toggles after release.
- **PARAM_INVERT=1:** repeat the reset scenario → outputs 1 during reset; all patterns inverted.
